// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS-subset core.
// Optional link support (jal/jr) is enabled by defining MCD_LINK_EN.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB,
        S_BRANCH, S_JUMP, S_HALT, S_JALST, S_JRST
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_LINK = 2'd2;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MDR = 2'd1;
    localparam logic [1:0] SRC_PC  = 2'd2;

    typedef struct packed {
        logic       ir_we;
        logic       ab_we;
        logic       br_calc;
        logic       imm_calc;
        logic       exec;
        logic       mdr_we;
        logic       rf_we;
        logic [1:0] dst;
        logic [1:0] src;
        logic       pc_br;
        logic       pc_j;
        logic       pc_jr;
    } ctrl_t;

    function automatic logic [2:0] alu_code(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_datapath_ctrl.sv
// Control FSM: state register, dispatch, timeout counter, strobes.
// Defining MCD_LINK_EN makes jal/jr legal.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output state_t     state,
    output ctrl_t      ctrl,
    output logic       mem_req,
    output logic       mem_we,
    output logic       err
);

    state_t     nxt;
    logic [7:0] tcnt;
    logic       is_mem;
    logic       done;
    logic       tout;

    function automatic logic mem_state(input state_t s);
        return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
    endfunction

    assign is_mem = mem_state(state);
    assign done   = mem_req && mem_ready;
    assign tout   = is_mem && !done && tcnt == 8'(TIMEOUT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= nxt;
    end

    // Next-state: sequencing, opcode dispatch, timeout override
    always_comb begin
        nxt = state;
        unique case (state)
            S_FETCH: if (done) nxt = S_DECODE;
            S_DECODE: begin
                nxt = S_HALT;
                case (op)
                    OP_R: begin
                        if (funct == FN_ADD || funct == FN_SUB ||
                            funct == FN_AND || funct == FN_OR  ||
                            funct == FN_SLT)
                            nxt = S_EXEC;
`ifdef MCD_LINK_EN
                        if (funct == FN_JR) nxt = S_JRST;
`endif
                    end
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
`ifdef MCD_LINK_EN
                    OP_JAL:       nxt = S_JALST;
`endif
                    default:      nxt = S_HALT;
                endcase
            end
            S_MEMADR: nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (done) nxt = S_MEMWB;
            S_MEMWR:  if (done) nxt = S_FETCH;
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
        if (tout) nxt = S_HALT;
    end

    // Registered bus strobes, halt cause and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b0;
            tcnt    <= '0;
        end else begin
            mem_req <= mem_state(nxt);
            mem_we  <= nxt == S_MEMWR;
            if (tout) err <= 1'b1;
            if (nxt != state)
                tcnt <= '0;
            else if (is_mem && !done)
                tcnt <= tcnt + 8'd1;
        end
    end

    // Per-state datapath strobes
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH:  ctrl.ir_we = done;
            S_DECODE: begin
                ctrl.ab_we   = 1'b1;
                ctrl.br_calc = 1'b1;
            end
            S_MEMADR: ctrl.imm_calc = 1'b1;
            S_ADDIEX: ctrl.imm_calc = 1'b1;
            S_MEMRD:  ctrl.mdr_we = done;
            S_MEMWB: begin
                ctrl.rf_we = 1'b1;
                ctrl.dst   = DST_RT;
                ctrl.src   = SRC_MDR;
            end
            S_EXEC:   ctrl.exec = 1'b1;
            S_ALUWB: begin
                ctrl.rf_we = 1'b1;
                ctrl.dst   = DST_RD;
                ctrl.src   = SRC_ALU;
            end
            S_ADDIWB: begin
                ctrl.rf_we = 1'b1;
                ctrl.dst   = DST_RT;
                ctrl.src   = SRC_ALU;
            end
            S_BRANCH: ctrl.pc_br = 1'b1;
            S_JUMP:   ctrl.pc_j = 1'b1;
            S_JALST: begin
                ctrl.pc_j  = 1'b1;
                ctrl.rf_we = 1'b1;
                ctrl.dst   = DST_LINK;
                ctrl.src   = SRC_PC;
            end
            S_JRST:   ctrl.pc_jr = 1'b1;
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core top: register file, ALU, datapath regs.
// Defining MCD_LINK_EN adds jal (writes LINK_REG) and jr.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int             n        = 32,
    parameter logic [n-1:0]   RESET_PC = '0,
    parameter int             LINK_REG = 15,
    parameter int             TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         reset,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    input  logic         mem_ready,
    output logic [n-1:0] pc,
    output logic         halt,
    output logic         err
);

    state_t       state;
    ctrl_t        c;
    logic [31:0]  ir;
    logic [n-1:0] a, b, aluout, mdr;
    logic [n-1:0] rf [32];
    logic [n-1:0] simm, jtarget, wd;
    logic [4:0]   rs, rt, rd, wa;

    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign simm    = {{(n-16){ir[15]}}, ir[15:0]};
    assign jtarget = {pc[n-1:28], ir[25:0], 2'b00};

    function automatic logic [n-1:0] alu(
        input logic [n-1:0] x,
        input logic [n-1:0] y,
        input logic [2:0]   code
    );
        case (code)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return {{(n-1){1'b0}}, $signed(x) < $signed(y)};
            default: return x + y;
        endcase
    endfunction

    mc_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .op        (ir[31:26]),
        .funct     (ir[5:0]),
        .mem_ready (mem_ready),
        .state     (state),
        .ctrl      (c),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .err       (err)
    );

    assign mem_addr  = (state == S_FETCH) ? pc : aluout;
    assign mem_wdata = b;
    assign halt      = state == S_HALT;

    // Write-back destination and source selection
    always_comb begin
        wa = rt;
        wd = aluout;
        case (c.dst)
            DST_RD:   wa = rd;
            DST_LINK: wa = 5'(LINK_REG);
            default:  wa = rt;
        endcase
        case (c.src)
            SRC_MDR: wd = mdr;
            SRC_PC:  wd = pc;
            default: wd = aluout;
        endcase
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (c.rf_we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    // PC, instruction and intermediate datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            if (c.ir_we) begin
                ir <= mem_rdata[31:0];
                pc <= pc + n'(4);
            end
            if (c.ab_we) begin
                a <= rf[rs];
                b <= rf[rt];
            end
            if (c.br_calc)  aluout <= pc + (simm << 2);
            if (c.imm_calc) aluout <= a + simm;
            if (c.exec)     aluout <= alu(a, b, alu_code(ir[5:0]));
            if (c.mdr_we)   mdr <= mem_rdata;
            if (c.pc_br && a == b) pc <= aluout;
            if (c.pc_j)     pc <= jtarget;
            if (c.pc_jr)    pc <= a;
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: an ISA-level model predicts every
// memory access; a monitor pops and compares as accesses complete.
module tb_mc_datapath;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, halt, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_ready = 1'b0;

    mc_datapath #(
        .n(32), .RESET_PC(RPC), .LINK_REG(15), .TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .halt(halt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic [31:0] mem [1024];
    logic [31:0] mm  [1024];
    logic [31:0] rr  [32];
    acc_t        exp_q [$];
    logic [31:0] m_halt_pc;
    int          errors = 0;
    int          checks = 0;
    bit          stuck = 1'b0;
    bit          link_en;
    int          wp;

    assign mem_rdata = mem[mem_addr[11:2]];

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] ri(input int fn, input int rs,
                                       input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] ii(input int op, input int rs,
                                       input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jj(input int op, input logic [31:0] t);
        return {6'(op), t[27:2]};
    endfunction

    task automatic emit(input logic [31:0] w);
        mem[wp] = w;
        wp++;
    endtask

    // ISA-level reference: executes the program, records accesses
    task automatic model();
        logic [31:0] p, ins, s, t, ea;
        logic [4:0]  rs, rt, rd;
        bit          stop;
        for (int i = 0; i < 1024; i++) mm[i] = mem[i];
        for (int i = 0; i < 32; i++) rr[i] = '0;
        exp_q.delete();
        p = RPC;
        for (int step = 0; step < 3000; step++) begin
            ins = mm[p[11:2]];
            exp_q.push_back('{we: 1'b0, addr: p, data: 32'h0});
            p = p + 32'd4;
            rs = ins[25:21];
            rt = ins[20:16];
            rd = ins[15:11];
            s = {{16{ins[15]}}, ins[15:0]};
            t = {p[31:28], ins[25:0], 2'b00};
            ea = rr[rs] + s;
            stop = 1'b0;
            case (ins[31:26])
                6'h00: case (ins[5:0])
                    6'h20: rr[rd] = rr[rs] + rr[rt];
                    6'h22: rr[rd] = rr[rs] - rr[rt];
                    6'h24: rr[rd] = rr[rs] & rr[rt];
                    6'h25: rr[rd] = rr[rs] | rr[rt];
                    6'h2A: rr[rd] = ($signed(rr[rs]) < $signed(rr[rt]))
                                    ? 32'd1 : 32'd0;
                    6'h08: if (link_en) p = rr[rs]; else stop = 1'b1;
                    default: stop = 1'b1;
                endcase
                6'h08: rr[rt] = ea;
                6'h23: begin
                    exp_q.push_back('{we: 1'b0, addr: ea, data: 32'h0});
                    rr[rt] = mm[ea[11:2]];
                end
                6'h2B: begin
                    exp_q.push_back('{we: 1'b1, addr: ea, data: rr[rt]});
                    mm[ea[11:2]] = rr[rt];
                end
                6'h04: if (rr[rs] == rr[rt]) p = p + (s << 2);
                6'h02: p = t;
                6'h03: if (link_en) begin
                    rr[15] = p;
                    p = t;
                end else stop = 1'b1;
                default: stop = 1'b1;
            endcase
            rr[0] = '0;
            if (stop) break;
        end
        m_halt_pc = p;
    endtask

    // Memory ready: random wait states unless forced stuck low
    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ready = stuck ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: request stability while waiting, and scoreboard pops
    logic        hold_v = 1'b0;
    logic [95:0] hold_s;
    always @(negedge clk) begin : mon
        acc_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && !halt)
                check("hold", 96'({mem_req, mem_we, mem_addr, mem_wdata}),
                      hold_s);
            hold_v = mem_req && !mem_ready;
            hold_s = 96'({mem_req, mem_we, mem_addr, mem_wdata});
            if (mem_req && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected access: addr %h we %b",
                             mem_addr, mem_we);
                end else begin
                    e = exp_q.pop_front();
                    if (e.we)
                        check("store", 96'({mem_we, mem_addr, mem_wdata}),
                              96'({1'b1, e.addr, e.data}));
                    else
                        check("read", 96'({mem_we, mem_addr}),
                              96'({1'b0, e.addr}));
                    if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                end
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state", 96'({pc, mem_req, mem_we, halt, err}),
              96'({RPC, 4'b0000}));
        reset = 1'b0;
    endtask

    task automatic run_phase(input string name);
        int i;
        model();
        reset_dut();
        i = 0;
        while (!(mem_req && mem_ready) && i < 100) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check({name, " decode pc"}, 96'(pc), 96'(RPC + 32'd4));
        i = 0;
        while (!halt && i < 20000) begin
            @(negedge clk);
            i++;
        end
        check({name, " halt"}, 96'({halt, err, pc}),
              96'({1'b1, 1'b0, m_halt_pc}));
        check({name, " drained"}, 96'(exp_q.size()), 96'(0));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFC00_0000;
        for (int i = 512; i < 576; i++) mem[i] = $urandom;
        wp = 64;
    endtask

    initial begin
`ifdef MCD_LINK_EN
        link_en = 1'b1;
`else
        link_en = 1'b0;
`endif
        // Directed: arithmetic, store, branches, loop, load
        clear_mem();
        emit(ii(8, 0, 1, 5));
        emit(ii(8, 0, 2, 7));
        emit(ri(32'h20, 1, 2, 3));
        emit(ii(32'h2B, 0, 3, 32'h40));
        emit(ii(4, 1, 1, 1));
        emit(ii(8, 0, 4, 99));
        emit(ii(4, 1, 2, 1));
        emit(ii(8, 0, 5, 3));
        emit(ii(8, 5, 5, -1));
        emit(ii(4, 5, 0, 1));
        emit(ii(4, 0, 0, -3));
        emit(ii(32'h23, 0, 6, 32'h40));
        emit(ri(32'h22, 1, 2, 7));
        emit(ri(32'h2A, 7, 1, 4));
        emit(ri(32'h25, 4, 3, 8));
        emit(ri(32'h24, 8, 2, 9));
        emit(jj(2, 32'(wp * 4 + 8)));
        emit(ii(8, 0, 9, 1));
        emit(ii(32'h2B, 0, 4, 32'h44));
        emit(ii(32'h2B, 0, 6, 32'h48));
        emit(ii(32'h2B, 0, 7, 32'h4C));
        emit(ii(32'h2B, 0, 8, 32'h50));
        emit(ii(32'h2B, 0, 9, 32'h54));
        emit(ii(32'h2B, 0, 5, 32'h58));
        run_phase("directed");

        // Randomized program over registers 0..7
        clear_mem();
        for (int k = 0; k < 60; k++) begin
            int op, fsel;
            op = int'($urandom_range(0, 6));
            fsel = int'($urandom_range(0, 4));
            case (op)
                1: emit(ri(fsel == 0 ? 32'h20 : fsel == 1 ? 32'h22 :
                           fsel == 2 ? 32'h24 : fsel == 3 ? 32'h25 : 32'h2A,
                           int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)),
                           int'($urandom_range(1, 7))));
                2: emit(ii(32'h2B, 0, int'($urandom_range(0, 7)),
                           32'h800 + 4 * int'($urandom_range(0, 63))));
                3: emit(ii(32'h23, 0, int'($urandom_range(1, 7)),
                           32'h800 + 4 * int'($urandom_range(0, 63))));
                4: emit(ii(4, int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 7)), 1));
                5: emit(jj(2, 32'(wp * 4 + 8)));
                default: emit(ii(8, int'($urandom_range(0, 7)),
                                 int'($urandom_range(1, 7)),
                                 int'($urandom_range(0, 65535))));
            endcase
        end
        for (int r = 1; r < 8; r++) emit(ii(32'h2B, 0, r, 32'h900 + 4 * r));
        run_phase("random");

        // Link: jal to 0x180, store $15, jr back
        clear_mem();
        emit(jj(3, 32'h180));
        emit(ii(8, 0, 1, 1));
        emit(ii(32'h2B, 0, 1, 32'h800));
        mem[96] = ii(32'h2B, 0, 15, 32'h804);
        mem[97] = ri(8, 15, 0, 0);
        run_phase("link");

        // Memory never ready: timeout halt with err=1
        clear_mem();
        exp_q.delete();
        stuck = 1'b1;
        reset_dut();
        repeat (200) @(negedge clk);
        check("no early timeout", 96'(halt), 96'(0));
        for (int i = 0; i < 200 && !halt; i++) @(negedge clk);
        check("timeout halt", 96'({halt, err, mem_req}), 96'(3'b110));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
